// File: rtl/screen_fill_if.sv
// Frame-RAM port-A bus of screen_fill_ctrl: CPU access, fill command, and the muxed RAM port.
// The err signal exists only when SCREEN_FILL_RANGE_CHECK_EN is defined.
interface screen_fill_if #(
    parameter int AW = 15,
    parameter int DW = 12
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          start;
    logic          abort;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] color;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          busy;
    logic          done;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
    logic          err;
`endif

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din, start, abort, base, len, color,
        input  ram_we, ram_addr, ram_din, busy, done
`ifdef SCREEN_FILL_RANGE_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din, start, abort, base, len, color,
        output ram_we, ram_addr, ram_din, busy, done
`ifdef SCREEN_FILL_RANGE_CHECK_EN
        , output err
`endif
    );
endinterface

// File: rtl/screen_fill_ctrl.sv
// Rectangle-free linear screen fill engine sharing frame-RAM port A with the CPU (CPU has priority).
// Optional start range check with sticky err: define SCREEN_FILL_RANGE_CHECK_EN.
module screen_fill_ctrl #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int DEPTH = 19200
) (
    input logic          clk,
    input logic          rst,
    screen_fill_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cur, cur_nxt;
    logic [AW:0]   rem, rem_nxt;
    logic [DW-1:0] pix, pix_nxt;
    logic          fill_wr;
    logic          start_ok;

    assign fill_wr = (state == FILL) && !bus.cpu_req;

`ifdef SCREEN_FILL_RANGE_CHECK_EN
    logic          err, err_nxt;
    logic [AW+1:0] end_addr;
    logic          range_bad;

    assign end_addr  = {2'b00, bus.base} + {1'b0, bus.len};
    assign range_bad = ({1'b0, bus.base} >= (AW+1)'(DEPTH)) || (end_addr > (AW+2)'(DEPTH));
    assign start_ok  = bus.start && !range_bad;
    assign bus.err   = err;
`else
    assign start_ok  = bus.start;
`endif

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        rem_nxt   = rem;
        pix_nxt   = pix;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
        err_nxt   = err;
`endif
        case (state)
            IDLE: begin
                if (start_ok) begin
                    cur_nxt   = bus.base;
                    rem_nxt   = bus.len;
                    pix_nxt   = bus.color;
                    state_nxt = (bus.len == '0) ? DONE : FILL;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
                    err_nxt   = 1'b0;
                end else if (bus.start) begin
                    err_nxt   = 1'b1;
`endif
                end
            end
            FILL: begin
                if (fill_wr) begin
                    cur_nxt = (cur == LAST) ? '0 : cur + 1'b1;
                    rem_nxt = rem - 1'b1;
                end
                // abort outranks completion; the write issued this cycle still lands
                if (bus.abort)
                    state_nxt = IDLE;
                else if (fill_wr && rem == (AW+1)'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (bus.cpu_req) begin
            bus.ram_we   = bus.cpu_we;
            bus.ram_addr = bus.cpu_addr;
            bus.ram_din  = bus.cpu_din;
        end else begin
            bus.ram_we   = (state == FILL);
            bus.ram_addr = cur;
            bus.ram_din  = pix;
        end
    end

    assign bus.busy = (state == FILL);
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cur   <= '0;
            rem   <= '0;
            pix   <= '0;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
            rem   <= rem_nxt;
            pix   <= pix_nxt;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
            err   <= err_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_screen_fill_ctrl.sv
// Testbench for screen_fill_ctrl: directed scenarios plus random traffic, checked each cycle
// against a queue-of-pending-addresses reference model. Honours SCREEN_FILL_RANGE_CHECK_EN.
module tb_screen_fill_ctrl;
    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int DEPTH = 19200;

    logic clk;
    logic rst;

    screen_fill_if #(.AW(AW), .DW(DW)) bus ();

    screen_fill_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: addresses still to be written, plus a pending done pulse
    int m_q[$];
    bit m_fill;
    bit m_done;
    int m_cur;
    int m_pix;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fill = 1'b0;
        m_done = 1'b0;
        m_cur  = 0;
        m_pix  = 0;
        m_err  = 1'b0;
    endtask

    task automatic step(input bit r, input bit req, input bit we, input int addr, input int din,
                        input bit st, input bit ab, input int b, input int l, input int c);
        int exp_we, exp_addr, exp_din, popped;
        bit bad;
        rst          = r;
        bus.cpu_req  = req;
        bus.cpu_we   = we;
        bus.cpu_addr = AW'(addr);
        bus.cpu_din  = DW'(din);
        bus.start    = st;
        bus.abort    = ab;
        bus.base     = AW'(b);
        bus.len      = (AW+1)'(l);
        bus.color    = DW'(c);
        @(negedge clk);
        if (req) begin
            exp_we = int'(we); exp_addr = addr; exp_din = din;
        end else if (m_fill) begin
            exp_we = 1; exp_addr = m_q[0]; exp_din = m_pix;
        end else begin
            exp_we = 0; exp_addr = m_cur; exp_din = m_pix;
        end
        check("ram_we",   32'(bus.ram_we),   32'(exp_we));
        check("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
        check("ram_din",  32'(bus.ram_din),  32'(exp_din));
        check("busy",     32'(bus.busy),     32'(m_fill));
        check("done",     32'(bus.done),     32'(m_done));
`ifdef SCREEN_FILL_RANGE_CHECK_EN
        check("err",      32'(bus.err),      32'(m_err));
`endif
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_fill) begin
            if (!req) begin
                popped = m_q.pop_front();
                m_cur  = (popped + 1) % DEPTH;
            end
            if (ab) begin
                m_fill = 1'b0;
                m_q.delete();
            end else if (m_q.size() == 0) begin
                m_fill = 1'b0;
                m_done = 1'b1;
            end
        end else if (st) begin
            bad = 1'b0;
`ifdef SCREEN_FILL_RANGE_CHECK_EN
            bad = (b >= DEPTH) || (b + l > DEPTH);
`endif
            if (bad) begin
                m_err = 1'b1;
            end else begin
                m_err = 1'b0;
                m_pix = c;
                m_cur = b;
                for (int i = 0; i < l; i++) m_q.push_back((b + i) % DEPTH);
                if (l == 0) m_done = 1'b1;
                else        m_fill = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fill(input int b, input int l, input int c);
        step(0, 0, 0, 0, 0, 1, 0, b, l, c);
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_din = '0;
        bus.start = 0; bus.abort = 0; bus.base = '0; bus.len = '0; bus.color = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state, then basic 4-pixel fill
        idle(1);
        fill(16'h0010, 4, 12'hF00);
        idle(6);

        // CPU steals two cycles mid-fill
        fill(16'h0200, 3, 12'h0A5);
        idle(1);
        step(0, 1, 1, 16'h0100, 12'h123, 0, 0, 0, 0, 0);
        step(0, 1, 1, 16'h0100, 12'h456, 0, 0, 0, 0, 0);
        idle(5);

        // zero-length fill
        fill(16'h0040, 0, 12'h777);
        idle(3);

        // wrap at end of frame (rejected when range check enabled)
        fill(DEPTH - 2, 4, 12'h0F0);
        idle(6);

        // abort after two writes; start while filling is ignored
        fill(16'h0300, 10, 12'h00F);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 0, 16'h0500, 2, 12'hABC);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(3);

        // abort in the completion cycle, abort during CPU stall
        fill(16'h0020, 2, 12'h321);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        fill(16'h0030, 3, 12'h654);
        step(0, 1, 0, 16'h0777, 12'h111, 0, 1, 0, 0, 0);
        idle(2);

        // reset mid-fill, with start asserted alongside
        fill(16'h0400, 8, 12'hFFF);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0010, 4, 12'h0EE);
        idle(2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int b;
            b = ($urandom_range(0, 1) == 0) ? DEPTH - 8 + int'($urandom_range(0, 7))
                                            : int'($urandom_range(0, DEPTH - 1));
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, (1 << AW) - 1)),
                 int'($urandom_range(0, (1 << DW) - 1)),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 31) == 0),
                 b,
                 int'($urandom_range(0, 12)),
                 int'($urandom_range(0, (1 << DW) - 1)));
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/screen_fill_ctrl.md
SCREEN_FILL_CTRL -- requirements
Module: screen_fill_ctrl

Interface
REQ-001 SHALL have parameter AW, default 15, frame-RAM address width.
REQ-002 SHALL have parameter DW, default 12, pixel width (RGB444).
REQ-003 SHALL have parameter DEPTH, default 19200, number of valid pixel words.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cpu_req  input  1  CPU access to frame RAM port A this cycle.
REQ-007 SHALL have port cpu_we  input  1  CPU write enable (meaningful only with cpu_req).
REQ-008 SHALL have port cpu_addr  input  AW  CPU pixel address.
REQ-009 SHALL have port cpu_din  input  DW  CPU write pixel.
REQ-010 SHALL have port start  input  1  single-cycle fill request.
REQ-011 SHALL have port abort  input  1  cancel an in-progress fill.
REQ-012 SHALL have port base  input  AW  first fill address, sampled on accepted start.
REQ-013 SHALL have port len  input  AW+1  pixel count, sampled on accepted start.
REQ-014 SHALL have port color  input  DW  fill pixel, sampled on accepted start.
REQ-015 SHALL have port ram_we  output  1  port-A write enable to frame RAM.
REQ-016 SHALL have port ram_addr  output  AW  port-A address.
REQ-017 SHALL have port ram_din  output  DW  port-A write data.
REQ-018 SHALL have port busy  output  1  high in FILL state.
REQ-019 SHALL have port done  output  1  one-cycle pulse on fill completion.

Function
REQ-020 SHALL implement FSM states IDLE, FILL, DONE; start accepted only in IDLE, ignored otherwise.
REQ-021 On accepted start: latch base->cur, len->rem, color->pix; next state FILL if len!=0, else DONE.
REQ-022 Port-A mux SHALL be combinational, CPU priority: cpu_req=1 -> ram_we=cpu_we, ram_addr=cpu_addr, ram_din=cpu_din.
REQ-023 In FILL with cpu_req=0: ram_we=1, ram_addr=cur, ram_din=pix; at clock edge cur+=1, rem-=1.
REQ-024 In FILL with cpu_req=1: fill stalls; cur, rem unchanged; no fill write issued.
REQ-025 When the write with rem==1 completes, next state SHALL be DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-026 Not FILL and cpu_req=0: ram_we=0, ram_addr=cur, ram_din=pix.
REQ-027 cur SHALL wrap from DEPTH-1 to 0.
REQ-028 abort in FILL SHALL go to IDLE next edge, no done pulse; the same-cycle fill write (if any) still occurs; abort ignored in IDLE/DONE.
REQ-029 abort and completion in same cycle: abort wins, no done.
REQ-030 Fill latency: len pixels with no CPU contention -> done asserted len+1 cycles after the start cycle.

Reset
REQ-031 rst SHALL force IDLE, cur=0, rem=0, pix=0, busy=0, done=0 at next edge, overriding start/abort, including mid-fill.
REQ-032 During rst the combinational mux still follows REQ-022/REQ-026.

Configuration
REQ-033 Macro SCREEN_FILL_RANGE_CHECK_EN: when defined, start with base+len>DEPTH or base>=DEPTH SHALL be rejected (stay IDLE, no done) and sticky output err (1 bit, reset 0, cleared by next accepted start) SHALL be set; when undefined, no err port exists and wrap per REQ-027 applies.

Verification
REQ-034 rst, start base=0x0010 len=4 color=0xF00, no cpu_req -> writes 0x0010..0x0013 data 0xF00 on consecutive cycles, done one cycle later, busy 4 cycles.
REQ-035 Fill len=3 with cpu_req=1 cpu_we=1 addr=0x0100 for 2 cycles mid-fill -> CPU writes pass through; fill completes 2 cycles late, all 3 fill addresses written once.
REQ-036 start len=0 -> no ram_we, done pulse next cycle, busy never high.
REQ-037 start base=DEPTH-2 len=4 (macro undefined) -> writes DEPTH-2, DEPTH-1, 0, 1; (macro defined) -> no writes, err=1.
REQ-038 abort after 2 of 10 writes -> IDLE, no done; second start during FILL ignored; rst mid-fill -> busy=0, ram_we=0 next cycle.
